ppu_oam_dma_writer: RTL and testbench
=====================================

Name: ppu_oam_dma_writer

Overview:
- Write side of sprite RAM (OAM). It is the counterpart of the PPU sprite-load reader, which scans OAM each scanline.
- Handles three CPU register writes:
  - OAMADDR ($2003) sets the OAM address pointer.
  - OAMDATA ($2004) writes one byte and post-increments the pointer.
  - OAMDMA ($4014) copies a 256-byte CPU page into OAM while halting the CPU.
- Sole writer of the spram write port. oam_addr drives the loader's cpu_sprite_addr.

Parameters:
- DMA_BYTES, 256, number of bytes transferred per DMA (fixed NES value; bench may shrink it for fast sims).

Ports:
- clk  in  1  system clock (one CPU cycle per clk)
- rst  in  1  synchronous, active-high reset
- oamaddr_wr  in  1  one-cycle strobe: CPU write to $2003
- oamdata_wr  in  1  one-cycle strobe: CPU write to $2004
- dma_wr  in  1  one-cycle strobe: CPU write to $4014
- cpu_data_in  in  8  CPU write data, valid with any strobe
- cpu_odd_cycle  in  1  1 when the current clk is an odd CPU cycle
- rendering  in  1  PPU is rendering (visible/pre-render line, rendering enabled)
- loader_busy  in  1  sprite-load FSM is reading spram; write port must not be used
- cpu_halt  out  1  stalls the CPU while DMA owns the bus
- dma_bus_addr  out  16  CPU-bus read address during DMA
- dma_bus_rd  out  1  CPU-bus read strobe; data returns on dma_bus_data the next cycle
- dma_bus_data  in  8  CPU-bus read data
- spram_wr_en  out  1  spram write enable
- spram_wr_addr  out  8  spram write address
- spram_wr_data  out  8  spram write data
- oam_addr  out  8  current OAM pointer
- dma_done  out  1  one-cycle pulse when the last DMA byte is written

Behaviour:
- All outputs are registered. Reset values:
  - cpu_halt, dma_bus_rd, spram_wr_en and dma_done are 0.
  - dma_bus_addr, spram_wr_addr, spram_wr_data and oam_addr are 0.
  - The state is IDLE.
- Reset mid-DMA aborts the transfer: on the next edge the state is IDLE, cpu_halt=0 and the remaining bytes are not written.
- Strobe priority in IDLE is dma_wr > oamaddr_wr > oamdata_wr. Lower-priority strobes in the same cycle are dropped.
- All strobes are ignored while the state is not IDLE.
- oamaddr_wr: oam_addr <= cpu_data_in on the next edge.
- oamdata_wr with rendering=0:
  - If loader_busy=0: issue spram_wr_en=1, spram_wr_addr=oam_addr, spram_wr_data=cpu_data_in in the cycle after the strobe. Then oam_addr <= oam_addr+1 (8-bit wrap, FF to 00).
  - If loader_busy=1: hold the byte in a 1-deep pending register. Write it on the first cycle with loader_busy=0, then increment. A new oamdata_wr while a byte is pending overwrites the pending byte, with no extra increment.
- oamdata_wr with rendering=1: no spram write; oam_addr <= oam_addr+4 (wraps).
- DMA state machine, states IDLE, HALT, ALIGN, READ, WRITE:
  - IDLE to HALT on dma_wr. Latch page=cpu_data_in, clear the 9-bit byte counter cnt, set cpu_halt=1.
  - HALT (1 cycle, dummy) goes to ALIGN if cpu_odd_cycle=1, otherwise to READ.
  - ALIGN (1 cycle) goes to READ.
  - READ asserts dma_bus_rd=1 with dma_bus_addr={page, cnt[7:0]}, then goes to WRITE.
  - WRITE captures dma_bus_data and stays in WRITE while loader_busy=1; no write is issued and cpu_halt stays 1. Once loader_busy=0 it issues spram_wr_en=1, spram_wr_addr=oam_addr+cnt[7:0] (8-bit wrap), spram_wr_data=captured byte, and increments cnt.
  - After the write, if cnt reaches DMA_BYTES: pulse dma_done, set cpu_halt=0 and go to IDLE. Otherwise go to READ.
- oam_addr is unchanged after a full 256-byte DMA, matching 256 wrapping increments.
- DMA duration with no loader stalls, from dma_wr to cpu_halt falling: 513 cycles (even start) or 514 cycles (odd start). Each loader_busy cycle during WRITE adds one cycle.
- dma_bus_rd is high only in READ; spram_wr_en is high only for a committed write; both are otherwise 0.
- A pending OAMDATA byte held when dma_wr arrives is written before HALT ends, in the HALT cycle if loader_busy=0. Otherwise the pending byte is dropped and the DMA proceeds.

Test Plan:
- oamaddr_wr data=0x10, then oamdata_wr 0xAA, 0xBB, loader_busy=0 -> spram writes (0x10,0xAA) then (0x11,0xBB); oam_addr=0x12.
- oam_addr=0xFF, oamdata_wr 0x55 -> write at 0xFF; oam_addr=0x00. With rendering=1 and oam_addr=0xFE, oamdata_wr -> no write, oam_addr=0x02.
- dma_wr data=0x02 on an even cycle, bus model returns low byte of address XOR 0x5A, oam_addr=0 -> 256 writes spram[i]=i^0x5A, reads at 0x0200..0x02FF, cpu_halt high 513 cycles, dma_done pulses once, oam_addr=0.
- Same DMA, odd cycle start, oam_addr=0x80 -> 514 halt cycles; byte i lands at (0x80+i)&0xFF; oam_addr ends at 0x80.
- During DMA hold loader_busy=1 for 10 cycles at byte 5 -> no spram_wr_en during the stall; byte 5 is written after the stall; total halt is 523 cycles; data is intact.
- rst=1 at byte 100 of a DMA -> next edge cpu_halt=0, state IDLE, oam_addr=0; no further writes; a new dma_wr afterwards runs a full transfer.

Source files
------------

// File: rtl/ppu_oam_dma_writer.sv
// ppu_oam_dma_writer
//   Write side of sprite RAM (OAM). Services CPU writes to OAMADDR ($2003),
//   OAMDATA ($2004) and OAMDMA ($4014). It is the only writer of the spram
//   write port. The sprite-load reader scans spram each scanline.
//
// Ports:
//   clk, rst           system clock (one CPU cycle per clk), sync active-high reset
//   oamaddr_wr         strobe: set OAM pointer from cpu_data_in
//   oamdata_wr         strobe: write cpu_data_in at the pointer, post-increment
//   dma_wr             strobe: start a page copy from CPU page cpu_data_in
//   cpu_data_in        CPU write data
//   cpu_odd_cycle      current CPU cycle is odd (DMA alignment)
//   rendering          PPU rendering; OAMDATA only bumps the pointer by 4
//   loader_busy        sprite loader owns spram this cycle; defer writes
//   cpu_halt           CPU stall while DMA owns the bus
//   dma_bus_addr/rd    CPU-bus read request; data returns next cycle
//   dma_bus_data       CPU-bus read data
//   spram_wr_en/addr/data  spram write port
//   oam_addr           current OAM pointer (feeds the loader)
//   dma_done           one-cycle pulse on the last DMA write
module ppu_oam_dma_writer #(
    parameter int DMA_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        oamaddr_wr,
    input  logic        oamdata_wr,
    input  logic        dma_wr,
    input  logic [7:0]  cpu_data_in,
    input  logic        cpu_odd_cycle,
    input  logic        rendering,
    input  logic        loader_busy,
    output logic        cpu_halt,
    output logic [15:0] dma_bus_addr,
    output logic        dma_bus_rd,
    input  logic [7:0]  dma_bus_data,
    output logic        spram_wr_en,
    output logic [7:0]  spram_wr_addr,
    output logic [7:0]  spram_wr_data,
    output logic [7:0]  oam_addr,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    localparam logic [8:0] LAST_CNT = 9'(DMA_BYTES);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  cap_q, cap_d;
    logic        cap_vld_q, cap_vld_d;
    logic        pend_vld_q, pend_vld_d;
    logic [7:0]  pend_data_q, pend_data_d;

    logic        cpu_halt_d, dma_bus_rd_d, spram_wr_en_d, dma_done_d;
    logic [15:0] dma_bus_addr_d;
    logic [7:0]  spram_wr_addr_d, spram_wr_data_d, oam_addr_d;

    logic [8:0]  cnt_inc;
    logic [7:0]  dma_byte;
    logic [7:0]  idle_byte;

    assign cnt_inc   = cnt_q + 9'd1;
    // Bus data is only valid in the first WRITE cycle; a loader stall
    // parks it in cap_q so it survives any number of stall cycles.
    assign dma_byte  = cap_vld_q ? cap_q : dma_bus_data;
    // A fresh OAMDATA byte replaces whatever is pending.
    assign idle_byte = oamdata_wr ? cpu_data_in : pend_data_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        page_d          = page_q;
        cap_d           = cap_q;
        cap_vld_d       = cap_vld_q;
        pend_vld_d      = pend_vld_q;
        pend_data_d     = pend_data_q;
        cpu_halt_d      = cpu_halt;
        dma_bus_addr_d  = dma_bus_addr;
        dma_bus_rd_d    = 1'b0;
        spram_wr_en_d   = 1'b0;
        spram_wr_addr_d = spram_wr_addr;
        spram_wr_data_d = spram_wr_data;
        oam_addr_d      = oam_addr;
        dma_done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dma_wr) begin
                    state_d    = S_HALT;
                    page_d     = cpu_data_in;
                    cnt_d      = 9'd0;
                    cap_vld_d  = 1'b0;
                    cpu_halt_d = 1'b1;
                end else if (oamaddr_wr) begin
                    oam_addr_d = cpu_data_in;
                end else if (oamdata_wr && rendering) begin
                    oam_addr_d = oam_addr + 8'd4;
                end else if (oamdata_wr || pend_vld_q) begin
                    if (!loader_busy) begin
                        spram_wr_en_d   = 1'b1;
                        spram_wr_addr_d = oam_addr;
                        spram_wr_data_d = idle_byte;
                        oam_addr_d      = oam_addr + 8'd1;
                        pend_vld_d      = 1'b0;
                    end else begin
                        pend_vld_d  = 1'b1;
                        pend_data_d = idle_byte;
                    end
                end
            end
            S_HALT: begin
                // Last chance for a deferred OAMDATA byte; otherwise it is lost.
                if (pend_vld_q && !loader_busy) begin
                    spram_wr_en_d   = 1'b1;
                    spram_wr_addr_d = oam_addr;
                    spram_wr_data_d = pend_data_q;
                    oam_addr_d      = oam_addr + 8'd1;
                end
                pend_vld_d = 1'b0;
                if (cpu_odd_cycle) begin
                    state_d = S_ALIGN;
                end else begin
                    state_d        = S_READ;
                    dma_bus_rd_d   = 1'b1;
                    dma_bus_addr_d = {page_q, cnt_q[7:0]};
                end
            end
            S_ALIGN: begin
                state_d        = S_READ;
                dma_bus_rd_d   = 1'b1;
                dma_bus_addr_d = {page_q, cnt_q[7:0]};
            end
            S_READ: begin
                state_d   = S_WRITE;
                cap_vld_d = 1'b0;
            end
            S_WRITE: begin
                if (loader_busy) begin
                    cap_d     = dma_byte;
                    cap_vld_d = 1'b1;
                end else begin
                    spram_wr_en_d   = 1'b1;
                    spram_wr_addr_d = oam_addr + cnt_q[7:0];
                    spram_wr_data_d = dma_byte;
                    cnt_d           = cnt_inc;
                    cap_vld_d       = 1'b0;
                    if (cnt_inc == LAST_CNT) begin
                        state_d    = S_IDLE;
                        cpu_halt_d = 1'b0;
                        dma_done_d = 1'b1;
                    end else begin
                        state_d        = S_READ;
                        dma_bus_rd_d   = 1'b1;
                        dma_bus_addr_d = {page_q, cnt_inc[7:0]};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 9'd0;
            cap_vld_q     <= 1'b0;
            pend_vld_q    <= 1'b0;
            cpu_halt      <= 1'b0;
            dma_bus_addr  <= 16'd0;
            dma_bus_rd    <= 1'b0;
            spram_wr_en   <= 1'b0;
            spram_wr_addr <= 8'd0;
            spram_wr_data <= 8'd0;
            oam_addr      <= 8'd0;
            dma_done      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cap_vld_q     <= cap_vld_d;
            pend_vld_q    <= pend_vld_d;
            cpu_halt      <= cpu_halt_d;
            dma_bus_addr  <= dma_bus_addr_d;
            dma_bus_rd    <= dma_bus_rd_d;
            spram_wr_en   <= spram_wr_en_d;
            spram_wr_addr <= spram_wr_addr_d;
            spram_wr_data <= spram_wr_data_d;
            oam_addr      <= oam_addr_d;
            dma_done      <= dma_done_d;
        end
    end

    // Data-only registers; their valid flags above are what reset clears.
    always_ff @(posedge clk) begin
        page_q      <= page_d;
        cap_q       <= cap_d;
        pend_data_q <= pend_data_d;
    end

endmodule

// File: tb/tb_ppu_oam_dma_writer.sv
module tb_ppu_oam_dma_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        oamaddr_wr, oamdata_wr, dma_wr;
    logic [7:0]  cpu_data_in;
    logic        cpu_odd_cycle, rendering, loader_busy;
    logic        cpu_halt;
    logic [15:0] dma_bus_addr;
    logic        dma_bus_rd;
    logic [7:0]  dma_bus_data = 8'h00;
    logic        spram_wr_en;
    logic [7:0]  spram_wr_addr, spram_wr_data, oam_addr;
    logic        dma_done;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mem [256];

    ppu_oam_dma_writer #(.DMA_BYTES(256)) dut (
        .clk(clk), .rst(rst),
        .oamaddr_wr(oamaddr_wr), .oamdata_wr(oamdata_wr), .dma_wr(dma_wr),
        .cpu_data_in(cpu_data_in), .cpu_odd_cycle(cpu_odd_cycle),
        .rendering(rendering), .loader_busy(loader_busy),
        .cpu_halt(cpu_halt), .dma_bus_addr(dma_bus_addr), .dma_bus_rd(dma_bus_rd),
        .dma_bus_data(dma_bus_data), .spram_wr_en(spram_wr_en),
        .spram_wr_addr(spram_wr_addr), .spram_wr_data(spram_wr_data),
        .oam_addr(oam_addr), .dma_done(dma_done)
    );

    always #5 clk = ~clk;

    // CPU bus model: a read returns (low address byte ^ 0x5A) one cycle later.
    always @(posedge clk)
        dma_bus_data <= dma_bus_rd ? (dma_bus_addr[7:0] ^ 8'h5A) : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       aw;
        logic       dw;
        logic [7:0] d;
        logic       rend;
        logic       busy;
        logic       exp_en;
        logic [7:0] exp_waddr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_oam;
    } vec_t;

    vec_t vecs [13];

    task automatic set_addr(input logic [7:0] a);
        oamaddr_wr = 1'b1; cpu_data_in = a;
        @(posedge clk); @(negedge clk);
        oamaddr_wr = 1'b0;
    endtask

    task automatic check_mem(input string name, input logic [7:0] base);
        int bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[8'(base + 8'(i))] !== (8'(i) ^ 8'h5A)) bad++;
        check(name, bad, 0);
    endtask

    // Runs one DMA from the current negedge; observes every cycle at negedge.
    task automatic run_dma(input logic [7:0] page, input logic odd,
                           input int stall_byte, input int stall_len, input int rst_byte,
                           output int halt_cyc, output int nwr, output int nrd,
                           output int ndone, output int stall_wr, output int rd_bad,
                           output logic [7:0] first_waddr, output logic [7:0] first_wdata,
                           output int timed_out);
        int  busy_rem = 0;
        bit  arm = 0, seen_halt = 0, rst_fired = 0;
        halt_cyc = 0; nwr = 0; nrd = 0; ndone = 0; stall_wr = 0; rd_bad = 0;
        first_waddr = 8'h00; first_wdata = 8'h00; timed_out = 1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        cpu_odd_cycle = odd;
        cpu_data_in = page; dma_wr = 1'b1;
        @(posedge clk); @(negedge clk);
        dma_wr = 1'b0; loader_busy = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cpu_halt) begin halt_cyc++; seen_halt = 1; end
            if (spram_wr_en) begin
                if (nwr == 0) begin first_waddr = spram_wr_addr; first_wdata = spram_wr_data; end
                mem[spram_wr_addr] = spram_wr_data;
                nwr++;
                if (loader_busy) stall_wr++;
            end
            if (dma_done) ndone++;
            if (dma_bus_rd) begin
                if (dma_bus_addr !== {page, 8'(nrd)}) rd_bad++;
                nrd++;
            end
            if (busy_rem > 0) begin
                busy_rem--;
                if (busy_rem == 0) loader_busy = 1'b0;
            end
            if (arm) begin loader_busy = 1'b1; busy_rem = stall_len; arm = 0; end
            if (dma_bus_rd && (nrd - 1) == stall_byte) arm = 1;
            if (rst_byte >= 0 && nwr == rst_byte && !rst_fired) begin rst = 1'b1; rst_fired = 1; end
            if (seen_halt && !cpu_halt) begin timed_out = 0; break; end
            @(negedge clk);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (spram_wr_en) nwr++;
            if (dma_done) ndone++;
        end
        cpu_odd_cycle = 1'b0;
        loader_busy = 1'b0;
    endtask

    initial begin
        int hc, nw, nr, nd, sw, rb, to;
        logic [7:0] fa, fd;

        rst = 1'b1; oamaddr_wr = 0; oamdata_wr = 0; dma_wr = 0; cpu_data_in = 0;
        cpu_odd_cycle = 0; rendering = 0; loader_busy = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_halt", cpu_halt, 0);
        check("rst_bus_rd", dma_bus_rd, 0);
        check("rst_wr_en", spram_wr_en, 0);
        check("rst_done", dma_done, 0);
        check("rst_bus_addr", dma_bus_addr, 0);
        check("rst_wr_addr", spram_wr_addr, 0);
        check("rst_wr_data", spram_wr_data, 0);
        check("rst_oam_addr", oam_addr, 0);
        rst = 1'b0;

        //           aw dw  d     rend busy en  waddr  wdata  oam
        vecs[0]  = '{1, 0, 8'h10, 0, 0, 0, 8'h00, 8'h00, 8'h10};
        vecs[1]  = '{0, 1, 8'hAA, 0, 0, 1, 8'h10, 8'hAA, 8'h11};
        vecs[2]  = '{0, 1, 8'hBB, 0, 0, 1, 8'h11, 8'hBB, 8'h12};
        vecs[3]  = '{1, 0, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'hFF};
        vecs[4]  = '{0, 1, 8'h55, 0, 0, 1, 8'hFF, 8'h55, 8'h00};
        vecs[5]  = '{1, 0, 8'hFE, 0, 0, 0, 8'h00, 8'h00, 8'hFE};
        vecs[6]  = '{0, 1, 8'h77, 1, 0, 0, 8'h00, 8'h00, 8'h02};
        vecs[7]  = '{0, 1, 8'h33, 0, 1, 0, 8'h00, 8'h00, 8'h02};
        vecs[8]  = '{0, 1, 8'h44, 0, 1, 0, 8'h00, 8'h00, 8'h02};
        vecs[9]  = '{0, 0, 8'h00, 0, 0, 1, 8'h02, 8'h44, 8'h03};
        vecs[10] = '{0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h03};
        vecs[11] = '{1, 1, 8'h20, 0, 0, 0, 8'h00, 8'h00, 8'h20};
        vecs[12] = '{0, 1, 8'h66, 0, 0, 1, 8'h20, 8'h66, 8'h21};

        for (int i = 0; i < 13; i++) begin
            oamaddr_wr = vecs[i].aw; oamdata_wr = vecs[i].dw; cpu_data_in = vecs[i].d;
            rendering = vecs[i].rend; loader_busy = vecs[i].busy;
            @(posedge clk); @(negedge clk);
            oamaddr_wr = 0; oamdata_wr = 0;
            check($sformatf("vec%0d_wr_en", i), spram_wr_en, vecs[i].exp_en);
            if (vecs[i].exp_en) begin
                check($sformatf("vec%0d_wr_addr", i), spram_wr_addr, vecs[i].exp_waddr);
                check($sformatf("vec%0d_wr_data", i), spram_wr_data, vecs[i].exp_wdata);
            end
            check($sformatf("vec%0d_oam_addr", i), oam_addr, vecs[i].exp_oam);
        end
        rendering = 0; loader_busy = 0;

        // Full DMA, even start, pointer 0.
        set_addr(8'h00);
        run_dma(8'h02, 1'b0, -1, 0, -1, hc, nw, nr, nd, sw, rb, fa, fd, to);
        check("dma0_timeout", to, 0);
        check("dma0_halt", hc, 513);
        check("dma0_writes", nw, 256);
        check("dma0_reads", nr, 256);
        check("dma0_rd_addr", rb, 0);
        check("dma0_done", nd, 1);
        check_mem("dma0_data", 8'h00);
        check("dma0_oam_addr", oam_addr, 8'h00);

        // Odd start, pointer 0x80.
        set_addr(8'h80);
        run_dma(8'h02, 1'b1, -1, 0, -1, hc, nw, nr, nd, sw, rb, fa, fd, to);
        check("dma1_timeout", to, 0);
        check("dma1_halt", hc, 514);
        check("dma1_writes", nw, 256);
        check("dma1_done", nd, 1);
        check_mem("dma1_data", 8'h80);
        check("dma1_oam_addr", oam_addr, 8'h80);

        // Loader stall of 10 cycles at byte 5.
        set_addr(8'h00);
        run_dma(8'h02, 1'b0, 5, 10, -1, hc, nw, nr, nd, sw, rb, fa, fd, to);
        check("stall_timeout", to, 0);
        check("stall_halt", hc, 523);
        check("stall_wr_during_busy", sw, 0);
        check("stall_writes", nw, 256);
        check_mem("stall_data", 8'h00);

        // Reset after 100 bytes, then a fresh full transfer.
        set_addr(8'h10);
        run_dma(8'h02, 1'b0, -1, 0, 100, hc, nw, nr, nd, sw, rb, fa, fd, to);
        check("rst_dma_timeout", to, 0);
        check("rst_dma_writes", nw, 100);
        check("rst_dma_done", nd, 0);
        check("rst_dma_halt_after", cpu_halt, 0);
        check("rst_dma_bus_rd_after", dma_bus_rd, 0);
        check("rst_dma_oam_addr", oam_addr, 8'h00);
        run_dma(8'h03, 1'b0, -1, 0, -1, hc, nw, nr, nd, sw, rb, fa, fd, to);
        check("post_rst_halt", hc, 513);
        check("post_rst_writes", nw, 256);
        check("post_rst_rd_addr", rb, 0);
        check_mem("post_rst_data", 8'h00);

        // Pending OAMDATA byte flushed in HALT before DMA data.
        set_addr(8'h40);
        loader_busy = 1'b1; oamdata_wr = 1'b1; cpu_data_in = 8'h99;
        @(posedge clk); @(negedge clk);
        oamdata_wr = 1'b0;
        check("pend_no_write", spram_wr_en, 0);
        check("pend_oam_hold", oam_addr, 8'h40);
        run_dma(8'h02, 1'b0, -1, 0, -1, hc, nw, nr, nd, sw, rb, fa, fd, to);
        check("pend_first_addr", fa, 8'h40);
        check("pend_first_data", fd, 8'h99);
        check("pend_writes", nw, 257);
        check("pend_halt", hc, 513);
        check_mem("pend_dma_data", 8'h41);
        check("pend_oam_addr", oam_addr, 8'h41);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
